// File: rtl/uart_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uart_bridge_pkg
// Shared definitions for the UART byte <-> 32-bit word bridge:
//   - tx_state_t : encoding of the transmit FSM in uart_word_bridge
//   - calc_nbytes: bytes per word for a given word / byte width
//   - width_ok   : legality of a word width / byte width pairing
//   - clog2_min1 : counter width helper that never returns zero
// No ports (package only).
// ---------------------------------------------------------------------------
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } tx_state_t;

    function automatic int calc_nbytes(input int nbits, input int dbits);
        return nbits / dbits;
    endfunction

    // A word must be a whole, non-zero number of bytes.
    function automatic bit width_ok(input int nbits, input int dbits);
        return (dbits > 0) && (nbits >= dbits) && ((nbits % dbits) == 0);
    endfunction

    // A one-bit counter is still needed when only a single value is used.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_word_rx.sv
// ---------------------------------------------------------------------------
// uart_word_rx
// Assembles NBITS/DBITS consecutive UART bytes, little-endian, into one word.
// A partial word that sees no new byte for RX_TIMEOUT cycles is discarded
// (RX_TIMEOUT = 0 disables this).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   uart_rx_done      : one-cycle pulse, uart_rx_data holds a new byte
//   uart_rx_data      : received byte
//   word_rx_done      : one-cycle pulse, word_rx_data was just updated
//   word_rx_data      : last complete word, held until the next one
//   rx_timeout        : one-cycle pulse, a partial word was dropped
// ---------------------------------------------------------------------------
module uart_word_rx
    import uart_bridge_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int DBITS      = 8,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx_done,
    input  logic [DBITS-1:0] uart_rx_data,
    output logic             word_rx_done,
    output logic [NBITS-1:0] word_rx_data,
    output logic             rx_timeout
);

    localparam int NBYTES = calc_nbytes(NBITS, DBITS);
    localparam int CW     = clog2_min1(NBYTES);
    localparam int TW     = clog2_min1(RX_TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);
    localparam bit            TMO_EN    = (RX_TIMEOUT > 0);

    logic [NBITS-1:0] shift_q;
    logic [NBITS-1:0] assembled;
    logic [CW-1:0]    byte_cnt;
    logic [TW-1:0]    tmo_cnt;

    // The shift register with the incoming byte already dropped into its
    // slot; used both to update the register and to publish a finished word
    // in the same edge as its last byte.
    always_comb begin
        assembled = shift_q;
        assembled[byte_cnt*DBITS +: DBITS] = uart_rx_data;
    end

    // A byte always takes priority over an expiring timeout, so a byte that
    // lands on the expiry cycle still belongs to the current word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q      <= '0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
            word_rx_data <= '0;
            word_rx_done <= 1'b0;
            rx_timeout   <= 1'b0;
        end else begin
            word_rx_done <= 1'b0;
            rx_timeout   <= 1'b0;
            if (uart_rx_done) begin
                shift_q <= assembled;
                tmo_cnt <= '0;
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt     <= '0;
                    word_rx_data <= assembled;
                    word_rx_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end else if (TMO_EN && (byte_cnt != '0)) begin
                if (tmo_cnt == TMO_LAST) begin
                    byte_cnt   <= '0;
                    tmo_cnt    <= '0;
                    rx_timeout <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/uart_word_bridge.sv
// ---------------------------------------------------------------------------
// uart_word_bridge
// Byte-to-word adapter between an 8-bit UART core and a 32-bit word
// interface. The RX path (uart_word_rx) gathers bytes into words; the TX
// FSM below splits a word into bytes and hands them to the UART transmitter
// one per handshake. Both paths run independently.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   uart_rx_done    : one-cycle pulse, new byte on uart_rx_data
//   uart_rx_data    : received byte
//   uart_tx_done    : one-cycle pulse, UART finished the current byte
//   uart_tx_start   : one-cycle pulse, send uart_tx_data
//   uart_tx_data    : byte to transmit (stable while waiting for tx_done)
//   word_rx_done    : one-cycle pulse, word_rx_data valid
//   word_rx_data    : assembled word
//   word_tx_start   : request to send word_tx_data (ignored while busy)
//   word_tx_data    : word to transmit
//   word_tx_done    : one-cycle pulse, all bytes of the word sent
//   tx_busy         : TX FSM not idle
//   rx_timeout      : one-cycle pulse, partial RX word discarded
// ---------------------------------------------------------------------------
module uart_word_bridge
    import uart_bridge_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int DBITS      = 8,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx_done,
    input  logic [DBITS-1:0] uart_rx_data,
    input  logic             uart_tx_done,
    output logic             uart_tx_start,
    output logic [DBITS-1:0] uart_tx_data,
    output logic             word_rx_done,
    output logic [NBITS-1:0] word_rx_data,
    input  logic             word_tx_start,
    input  logic [NBITS-1:0] word_tx_data,
    output logic             word_tx_done,
    output logic             tx_busy,
    output logic             rx_timeout
);

    localparam int NBYTES = calc_nbytes(NBITS, DBITS);
    localparam int IW     = clog2_min1(NBYTES);

    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    generate
        if (!width_ok(NBITS, DBITS)) begin : g_width_check
            $error("uart_word_bridge: NBITS must be a non-zero multiple of DBITS");
        end
    endgenerate

    uart_word_rx #(
        .NBITS      (NBITS),
        .DBITS      (DBITS),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_done (uart_rx_done),
        .uart_rx_data (uart_rx_data),
        .word_rx_done (word_rx_done),
        .word_rx_data (word_rx_data),
        .rx_timeout   (rx_timeout)
    );

    tx_state_t        state;
    tx_state_t        state_next;
    logic [NBITS-1:0] word_q;
    logic [IW-1:0]    idx;
    logic             load_word;
    logic             idx_inc;

    // State register plus the latched word and byte index. The word is only
    // loaded from IDLE, so a start request during a transfer cannot disturb
    // the bytes still to be sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            word_q <= '0;
            idx    <= '0;
        end else begin
            state <= state_next;
            if (load_word) begin
                word_q <= word_tx_data;
                idx    <= '0;
            end else if (idx_inc) begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Next-state logic. uart_tx_done is only looked at in WAIT; anywhere
    // else it is ignored.
    always_comb begin
        state_next = state;
        load_word  = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (word_tx_start) begin
                    load_word  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (uart_tx_done) begin
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = SEND;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only. uart_tx_data follows the index
    // register, so it stays put for the whole SEND/WAIT period of a byte.
    assign uart_tx_start = (state == SEND);
    assign word_tx_done  = (state == DONE);
    assign tx_busy       = (state != IDLE);
    assign uart_tx_data  = word_q[idx*DBITS +: DBITS];

endmodule

// File: tb/tb_uart_word_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_word_bridge
// Scoreboard bench for uart_word_bridge. Driver tasks feed bytes and words
// and push the expected responses (words, bytes, pulses and the cycle they
// are due) into queues; a monitor on the falling edge pops and compares
// whenever the DUT raises one of its output strobes. A responder plays the
// UART transmitter, answering each uart_tx_start with uart_tx_done.
// ---------------------------------------------------------------------------
module tb_uart_word_bridge;

    localparam int NBITS  = 32;
    localparam int DBITS  = 8;
    localparam int TMO    = 16;
    localparam int NBYTES = NBITS / DBITS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             uart_rx_done = 1'b0;
    logic [DBITS-1:0] uart_rx_data = '0;
    logic             uart_tx_done = 1'b0;
    logic             uart_tx_start;
    logic [DBITS-1:0] uart_tx_data;
    logic             word_rx_done;
    logic [NBITS-1:0] word_rx_data;
    logic             word_tx_start = 1'b0;
    logic [NBITS-1:0] word_tx_data = '0;
    logic             word_tx_done;
    logic             tx_busy;
    logic             rx_timeout;

    uart_word_bridge #(
        .NBITS      (NBITS),
        .DBITS      (DBITS),
        .RX_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_done  (uart_rx_done),
        .uart_rx_data  (uart_rx_data),
        .uart_tx_done  (uart_tx_done),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .word_rx_done  (word_rx_done),
        .word_rx_data  (word_rx_data),
        .word_tx_start (word_tx_start),
        .word_tx_data  (word_tx_data),
        .word_tx_done  (word_tx_done),
        .tx_busy       (tx_busy),
        .rx_timeout    (rx_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Reference model state and scoreboard queues.
    logic [7:0]  rx_partial[$];
    int          idle_cnt = 0;
    logic [31:0] last_rx_word = '0;
    logic        tx_busy_m = 1'b0;
    logic [31:0] exp_rx_words[$];
    int          exp_rx_cyc[$];
    int          exp_to_cyc[$];
    logic [7:0]  exp_tx_bytes[$];
    int          exp_tx_cyc[$];
    logic [31:0] exp_tx_words[$];
    int          resp_delay = 10;
    int          resp_cnt = 0;
    int          last_txd_cyc = 0;
    logic [7:0]  cur_tx_byte = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] act);
        checks++;
        $display("[TB] FAIL %s: got a pulse with value %h, expected no pulse (cycle %0d)", name, act, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One received byte. The model keeps the bytes of the pending word and,
    // on the last one, expects the little-endian composition one cycle later.
    task automatic rx_byte(input logic [7:0] b);
        logic [31:0] w;
        uart_rx_done = 1'b1;
        uart_rx_data = b;
        tick();
        uart_rx_done = 1'b0;
        uart_rx_data = 8'($urandom);
        idle_cnt = 0;
        rx_partial.push_back(b);
        if (rx_partial.size() == NBYTES) begin
            w = 0;
            for (int i = 0; i < NBYTES; i++) w = w + (32'(rx_partial[i]) << (8 * i));
            exp_rx_words.push_back(w);
            exp_rx_cyc.push_back(cyc);
            last_rx_word = w;
            rx_partial.delete();
        end
    endtask

    // Idle RX cycles. After TMO quiet cycles a partial word must be dropped.
    task automatic rx_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idle_cnt++;
            if (rx_partial.size() > 0 && idle_cnt == TMO) begin
                exp_to_cyc.push_back(cyc);
                rx_partial.delete();
            end
        end
    endtask

    // One word request. Accepted only when the model says the bridge is idle.
    task automatic apply_stimulus(input logic [31:0] w);
        word_tx_start = 1'b1;
        word_tx_data  = w;
        if (!tx_busy_m) begin
            tx_busy_m = 1'b1;
            for (int i = 0; i < NBYTES; i++) begin
                exp_tx_bytes.push_back(8'(w >> (8 * i)));
                exp_tx_cyc.push_back((i == 0) ? cyc + 1 : -1);
            end
            exp_tx_words.push_back(w);
        end
        tick();
        word_tx_start = 1'b0;
        word_tx_data  = $urandom;
    endtask

    task automatic wait_tx_idle(input int limit);
        int n = 0;
        while (tx_busy_m && n < limit) begin
            tick();
            n++;
        end
        if (tx_busy_m) begin
            report_unexpected("tx_idle_wait_expired", 32'(n));
            tx_busy_m = 1'b0;
            exp_tx_bytes.delete();
            exp_tx_cyc.delete();
            exp_tx_words.delete();
        end
        check_output("tx_busy_after_word", 32'(tx_busy), 32'd0);
    endtask

    // Assert reset, check every output is cleared, and flush the model.
    task automatic apply_reset(input int n);
        rst = 1'b0;
        uart_rx_done = 1'b0;
        word_tx_start = 1'b0;
        uart_tx_done = 1'b0;
        resp_cnt = 0;
        rx_partial.delete();
        exp_rx_words.delete();
        exp_rx_cyc.delete();
        exp_to_cyc.delete();
        exp_tx_bytes.delete();
        exp_tx_cyc.delete();
        exp_tx_words.delete();
        idle_cnt = 0;
        last_rx_word = '0;
        tx_busy_m = 1'b0;
        #1;
        check_output("rst_uart_tx_start", 32'(uart_tx_start), 32'd0);
        check_output("rst_uart_tx_data", 32'(uart_tx_data), 32'd0);
        check_output("rst_word_rx_done", 32'(word_rx_done), 32'd0);
        check_output("rst_word_rx_data", word_rx_data, 32'd0);
        check_output("rst_word_tx_done", 32'(word_tx_done), 32'd0);
        check_output("rst_tx_busy", 32'(tx_busy), 32'd0);
        check_output("rst_rx_timeout", 32'(rx_timeout), 32'd0);
        repeat (n) tick();
        rst = 1'b1;
    endtask

    // UART transmitter stand-in: uart_tx_done resp_delay cycles after a start.
    always @(posedge clk) begin
        #1;
        uart_tx_done = 1'b0;
        if (rst && resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                uart_tx_done = 1'b1;
                last_txd_cyc = cyc;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT raises an output strobe.
    always @(negedge clk) begin
        logic [31:0] ew;
        int          ec;
        if (rst) begin
            if (word_rx_done) begin
                if (exp_rx_words.size() == 0) report_unexpected("rx_word_spurious", word_rx_data);
                else begin
                    ew = exp_rx_words.pop_front();
                    ec = exp_rx_cyc.pop_front();
                    check_output("rx_word", word_rx_data, ew);
                    check_output("rx_word_latency", 32'(cyc), 32'(ec));
                end
            end
            if (rx_timeout) begin
                if (exp_to_cyc.size() == 0) report_unexpected("rx_timeout_spurious", 32'(cyc));
                else begin
                    ec = exp_to_cyc.pop_front();
                    check_output("rx_timeout_cycle", 32'(cyc), 32'(ec));
                    check_output("rx_timeout_word_hold", word_rx_data, last_rx_word);
                end
            end
            if (uart_tx_start) begin
                if (exp_tx_bytes.size() == 0) report_unexpected("tx_byte_spurious", 32'(uart_tx_data));
                else begin
                    ew = 32'(exp_tx_bytes.pop_front());
                    ec = exp_tx_cyc.pop_front();
                    check_output("tx_byte", 32'(uart_tx_data), ew);
                    if (ec >= 0) check_output("tx_start_latency", 32'(cyc), 32'(ec));
                    check_output("tx_busy_while_sending", 32'(tx_busy), 32'd1);
                end
                cur_tx_byte = uart_tx_data;
                resp_cnt = resp_delay;
            end else if (tx_busy && !word_tx_done) begin
                check_output("tx_byte_stable", 32'(uart_tx_data), 32'(cur_tx_byte));
            end
            if (word_tx_done) begin
                if (exp_tx_words.size() == 0) report_unexpected("tx_done_spurious", 32'(cyc));
                else begin
                    void'(exp_tx_words.pop_front());
                    check_output("tx_done_latency", 32'(cyc), 32'(last_txd_cyc + 1));
                    check_output("tx_bytes_all_sent", 32'(exp_tx_bytes.size()), 32'd0);
                end
                tx_busy_m = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        apply_reset(3);

        // RX assembly of 0x12345678.
        rx_byte(8'h78); rx_idle(10);
        rx_byte(8'h56); rx_idle(10);
        rx_byte(8'h34); rx_idle(10);
        rx_byte(8'h12); rx_idle(5);

        // TX serialisation of 0xDEADBEEF.
        resp_delay = 10;
        apply_stimulus(32'hDEADBEEF);
        wait_tx_idle(200);

        // RX timeout, then a clean word, then a byte landing on the expiry cycle.
        rx_byte(8'hAA); rx_byte(8'hBB); rx_idle(TMO);
        rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
        rx_byte(8'h55); rx_idle(TMO - 1); rx_byte(8'h66); rx_idle(TMO - 1);
        rx_byte(8'h77); rx_byte(8'h88); rx_idle(3);

        // Busy start ignored while RX runs back-to-back.
        fork
            begin
                apply_stimulus(32'hCAFEF00D);
                repeat (5) tick();
                apply_stimulus(32'h11111111);
                wait_tx_idle(200);
            end
            begin
                rx_idle(2);
                rx_byte(8'hA1); rx_byte(8'hB2); rx_byte(8'hC3); rx_byte(8'hD4);
                rx_idle(2);
            end
        join

        // Reset in the middle of a TX word and an RX word.
        fork
            begin
                int n = 0;
                apply_stimulus($urandom);
                while (exp_tx_bytes.size() > 2 && n < 200) begin
                    tick();
                    n++;
                end
            end
            begin
                rx_byte(8'($urandom)); rx_byte(8'($urandom));
            end
        join
        apply_reset(4);
        fork
            begin
                apply_stimulus(32'h5AA5C33C);
                wait_tx_idle(200);
            end
            begin
                rx_byte(8'h10); rx_byte(8'h20); rx_byte(8'h30); rx_byte(8'h40);
                rx_idle(2);
            end
        join

        // Randomised concurrent traffic.
        fork
            begin
                repeat (40) begin
                    int r;
                    rx_byte(8'($urandom));
                    r = $urandom_range(0, 9);
                    if (r == 0) rx_idle(TMO + $urandom_range(0, 3));
                    else if (r == 1) rx_idle(TMO - 1);
                    else rx_idle($urandom_range(0, 3));
                end
                rx_idle(TMO + 2);
            end
            begin
                repeat (15) begin
                    resp_delay = $urandom_range(1, 12);
                    apply_stimulus($urandom);
                    repeat ($urandom_range(0, 30)) tick();
                end
                wait_tx_idle(500);
            end
        join

        repeat (4) tick();
        check_output("rx_words_drained", 32'(exp_rx_words.size()), 32'd0);
        check_output("rx_timeouts_drained", 32'(exp_to_cyc.size()), 32'd0);
        check_output("tx_bytes_drained", 32'(exp_tx_bytes.size()), 32'd0);
        check_output("tx_words_drained", 32'(exp_tx_words.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
